bcd_timer_ctrl: RTL and testbench

BCD_TIMER_CTRL -- requirements
Module: bcd_timer_ctrl

---
 rtl/bcd_timer_ctrl.sv | 92 +++++++++
 tb/tb_bcd_timer_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl: two-digit BCD timer controller driving external digit counters; define BCD_TIMER_AUTORELOAD_EN for periodic auto-reload
module bcd_timer_ctrl (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic       abort,
    input  logic       pause,
    input  logic       tick,
    input  logic       dir,
    input  logic [3:0] preset_ones,
    input  logic [3:0] preset_tens,
    input  logic [3:0] q_ones,
    input  logic [3:0] q_tens,
    output logic [3:0] d_ones,
    output logic [3:0] d_tens,
    output logic       en_ones,
    output logic       en_tens,
    output logic       load,
    output logic       up,
    output logic       busy,
    output logic       done,
    output logic [1:0] state
);
    typedef enum logic [1:0] {S_IDLE = 2'b00, S_LOAD = 2'b01, S_RUN = 2'b10, S_DONE = 2'b11} state_t;
    state_t state_q, state_d;
    logic [3:0] p_ones, p_tens;
    logic dir_q, term, ones_edge, take, step_ok;
    assign term = dir_q ? (q_tens == 4'd9 && q_ones == 4'd9) : (q_tens == 4'd0 && q_ones == 4'd0);
    assign ones_edge = dir_q ? (q_ones == 4'd9) : (q_ones == 4'd0);
    assign step_ok = tick & ~pause & ~term;
    assign take = start & ~abort & (state_q == S_IDLE || state_q == S_DONE);
    // state register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state_q <= S_IDLE;
        else state_q <= state_d;
    end
    // run parameters, captured only when a run is accepted; digits above 9 saturate
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            p_ones <= 4'd0;
            p_tens <= 4'd0;
            dir_q  <= 1'b1;
        end else if (take) begin
            p_ones <= (preset_ones > 4'd9) ? 4'd9 : preset_ones;
            p_tens <= (preset_tens > 4'd9) ? 4'd9 : preset_tens;
            dir_q  <= dir;
        end
    end
    // next state and digit-counter strobes; abort overrides everything
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        en_ones = 1'b0;
        en_tens = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: if (take) state_d = S_LOAD;
            S_LOAD: begin
                load    = 1'b1;
                en_ones = 1'b1;
                en_tens = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: begin
                en_ones = step_ok;
                en_tens = step_ok & ones_edge;
`ifdef BCD_TIMER_AUTORELOAD_EN
                if (term) state_d = S_LOAD;
`else
                if (term) state_d = S_DONE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end
`ifdef BCD_TIMER_AUTORELOAD_EN
    logic pulse_q;
    // one-cycle completion pulse marking each reload
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) pulse_q <= 1'b0;
        else pulse_q <= (state_q == S_RUN) && (state_d == S_LOAD);
    end
    assign done = pulse_q;
`else
    assign done = (state_q == S_DONE);
`endif
    assign busy   = (state_q == S_LOAD) || (state_q == S_RUN);
    assign up     = dir_q;
    assign d_ones = p_ones;
    assign d_tens = p_tens;
    assign state  = state_q;
endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// tb_bcd_timer_ctrl: vector-table bench for bcd_timer_ctrl with behavioural BCD digit counters attached
module tb_bcd_timer_ctrl;
    logic clk = 1'b0;
    logic clr, start, abort, pause, tick, dir;
    logic [3:0] preset_ones, preset_tens, q_ones, q_tens, d_ones, d_tens;
    logic en_ones, en_tens, load, up, busy, done;
    logic [1:0] state;
    localparam logic [1:0] ST_I = 2'd0, ST_L = 2'd1, ST_R = 2'd2, ST_D = 2'd3;
    typedef struct packed {
        logic [1:0] st;
        logic [3:0] qt, qo;
        logic eo, et, ld, bs, dn, u;
        logic [3:0] dt, dv;
    } exp_t;
    typedef struct {
        logic c, s, a, p, t, d;
        logic [3:0] pt, po;
        exp_t e;
    } vec_t;
    vec_t tbl[$];
    exp_t sb[$];
    int n_cmp = 0, n_fail = 0;
    bcd_timer_ctrl dut (
        .clk(clk), .clr(clr), .start(start), .abort(abort), .pause(pause), .tick(tick), .dir(dir),
        .preset_ones(preset_ones), .preset_tens(preset_tens), .q_ones(q_ones), .q_tens(q_tens),
        .d_ones(d_ones), .d_tens(d_tens), .en_ones(en_ones), .en_tens(en_tens), .load(load),
        .up(up), .busy(busy), .done(done), .state(state)
    );
    always #5 clk = ~clk;
    // external BCD digit counters
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q_ones <= 4'd0;
            q_tens <= 4'd0;
        end else begin
            if (load) q_ones <= d_ones;
            else if (en_ones) q_ones <= up ? ((q_ones == 4'd9) ? 4'd0 : q_ones + 4'd1) : ((q_ones == 4'd0) ? 4'd9 : q_ones - 4'd1);
            if (load) q_tens <= d_tens;
            else if (en_tens) q_tens <= up ? ((q_tens == 4'd9) ? 4'd0 : q_tens + 4'd1) : ((q_tens == 4'd0) ? 4'd9 : q_tens - 4'd1);
        end
    end
    function automatic exp_t ex(input logic [1:0] st, input logic [3:0] qt, qo, input logic eo, et, ld, bs, dn, u, input logic [3:0] dt, dv);
        ex = {st, qt, qo, eo, et, ld, bs, dn, u, dt, dv};
    endfunction
    task automatic add(input logic c, s, a, p, t, d, input logic [3:0] pt, po, input exp_t e);
        vec_t v;
        v.c = c; v.s = s; v.a = a; v.p = p; v.t = t; v.d = d; v.pt = pt; v.po = po; v.e = e;
        tbl.push_back(v);
    endtask
    task automatic check(input int idx);
        exp_t act, e;
        act = {state, q_tens, q_ones, en_ones, en_tens, load, busy, done, up, d_tens, d_ones};
        e = sb.pop_front();
        n_cmp++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL vec%0d: got %h want %h", idx, act, e);
        end
    endtask
    task automatic step(input vec_t v, input int idx);
        @(negedge clk);
        clr = v.c; start = v.s; abort = v.a; pause = v.p; tick = v.t; dir = v.d;
        preset_tens = v.pt; preset_ones = v.po;
        sb.push_back(v.e);
        #2;
        check(idx);
    endtask
    initial begin
        clr = 1'b0; start = 1'b0; abort = 1'b0; pause = 1'b0; tick = 1'b0; dir = 1'b0;
        preset_ones = 4'd0; preset_tens = 4'd0;
        // reset held, start ignored; then 2/1 countdown loaded and aborted
        add(0, 1, 0, 0, 1, 0, 3, 3, ex(ST_I, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        add(0, 1, 0, 0, 1, 0, 3, 3, ex(ST_I, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        add(1, 1, 0, 0, 0, 0, 2, 1, ex(ST_I, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        add(1, 0, 0, 0, 0, 0, 0, 0, ex(ST_L, 0, 0, 1, 1, 1, 1, 0, 0, 2, 1));
        add(1, 0, 0, 0, 0, 0, 0, 0, ex(ST_R, 2, 1, 0, 0, 0, 1, 0, 0, 2, 1));
        add(1, 0, 1, 0, 1, 0, 0, 0, ex(ST_R, 2, 1, 1, 0, 0, 1, 0, 0, 2, 1));
        add(1, 0, 0, 0, 1, 0, 0, 0, ex(ST_I, 2, 0, 0, 0, 0, 0, 0, 0, 2, 1));
        add(1, 1, 1, 0, 0, 1, 5, 5, ex(ST_I, 2, 0, 0, 0, 0, 0, 0, 0, 2, 1));
        add(1, 0, 0, 0, 0, 0, 0, 0, ex(ST_I, 2, 0, 0, 0, 0, 0, 0, 0, 2, 1));
        // asynchronous reset in the middle of a run
        add(1, 1, 0, 0, 0, 0, 5, 5, ex(ST_I, 2, 0, 0, 0, 0, 0, 0, 0, 2, 1));
        add(1, 0, 0, 0, 0, 0, 0, 0, ex(ST_L, 2, 0, 1, 1, 1, 1, 0, 0, 5, 5));
        add(1, 0, 0, 0, 1, 0, 0, 0, ex(ST_R, 5, 5, 1, 0, 0, 1, 0, 0, 5, 5));
        add(0, 0, 0, 0, 1, 0, 0, 0, ex(ST_I, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        add(1, 0, 0, 0, 1, 0, 0, 0, ex(ST_I, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        add(1, 0, 0, 0, 1, 0, 0, 0, ex(ST_I, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
`ifdef BCD_TIMER_AUTORELOAD_EN
        // 0/2 countdown reloading twice, start in RUN ignored, then abort
        add(1, 1, 0, 0, 0, 0, 0, 2, ex(ST_I, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        add(1, 0, 0, 0, 1, 0, 0, 0, ex(ST_L, 0, 0, 1, 1, 1, 1, 0, 0, 0, 2));
        for (int p = 0; p < 2; p++) begin
            add(1, 0, 0, 0, 1, 0, 0, 0, ex(ST_R, 0, 2, 1, 0, 0, 1, 0, 0, 0, 2));
            add(1, 0, 0, 0, 1, 0, 0, 0, ex(ST_R, 0, 1, 1, 0, 0, 1, 0, 0, 0, 2));
            add(1, 0, 0, 0, 1, 0, 0, 0, ex(ST_R, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2));
            add(1, 0, 0, 0, 1, 0, 0, 0, ex(ST_L, 0, 0, 1, 1, 1, 1, 1, 0, 0, 2));
        end
        add(1, 1, 0, 0, 1, 1, 5, 5, ex(ST_R, 0, 2, 1, 0, 0, 1, 0, 0, 0, 2));
        add(1, 0, 1, 0, 1, 0, 0, 0, ex(ST_R, 0, 1, 1, 0, 0, 1, 0, 0, 0, 2));
        add(1, 0, 0, 0, 1, 0, 0, 0, ex(ST_I, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
`else
        // 1/0 countdown with borrow to 00, then DONE held
        add(1, 1, 0, 0, 1, 0, 1, 0, ex(ST_I, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        add(1, 0, 0, 0, 1, 0, 0, 0, ex(ST_L, 0, 0, 1, 1, 1, 1, 0, 0, 1, 0));
        add(1, 0, 0, 0, 1, 0, 0, 0, ex(ST_R, 1, 0, 1, 1, 0, 1, 0, 0, 1, 0));
        for (int k = 9; k >= 1; k--)
            add(1, 0, 0, 0, 1, 0, 0, 0, ex(ST_R, 0, 4'(k), 1, 0, 0, 1, 0, 0, 1, 0));
        add(1, 0, 0, 0, 1, 0, 0, 0, ex(ST_R, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        add(1, 0, 0, 0, 1, 0, 0, 0, ex(ST_D, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        // 9/7 up-count with pause and an ignored start
        add(1, 1, 0, 0, 0, 1, 9, 7, ex(ST_D, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        add(1, 0, 0, 0, 0, 0, 0, 0, ex(ST_L, 0, 0, 1, 1, 1, 1, 0, 1, 9, 7));
        add(1, 0, 0, 0, 1, 0, 0, 0, ex(ST_R, 9, 7, 1, 0, 0, 1, 0, 1, 9, 7));
        add(1, 0, 0, 1, 1, 0, 0, 0, ex(ST_R, 9, 8, 0, 0, 0, 1, 0, 1, 9, 7));
        add(1, 1, 0, 1, 1, 0, 0, 0, ex(ST_R, 9, 8, 0, 0, 0, 1, 0, 1, 9, 7));
        add(1, 0, 0, 1, 1, 0, 0, 0, ex(ST_R, 9, 8, 0, 0, 0, 1, 0, 1, 9, 7));
        add(1, 0, 0, 0, 1, 0, 0, 0, ex(ST_R, 9, 8, 1, 0, 0, 1, 0, 1, 9, 7));
        add(1, 0, 0, 0, 1, 0, 0, 0, ex(ST_R, 9, 9, 0, 0, 0, 1, 0, 1, 9, 7));
        add(1, 0, 0, 0, 0, 0, 0, 0, ex(ST_D, 9, 9, 0, 0, 0, 0, 1, 1, 9, 7));
        // terminal presets: 0/0 down, saturated C/C up, then abort from DONE
        add(1, 1, 0, 0, 0, 0, 0, 0, ex(ST_D, 9, 9, 0, 0, 0, 0, 1, 1, 9, 7));
        add(1, 0, 0, 0, 0, 0, 0, 0, ex(ST_L, 9, 9, 1, 1, 1, 1, 0, 0, 0, 0));
        add(1, 0, 0, 0, 1, 0, 0, 0, ex(ST_R, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        add(1, 1, 0, 0, 0, 1, 4'hC, 4'hC, ex(ST_D, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        add(1, 0, 0, 0, 0, 0, 0, 0, ex(ST_L, 0, 0, 1, 1, 1, 1, 0, 1, 9, 9));
        add(1, 0, 0, 0, 1, 0, 0, 0, ex(ST_R, 9, 9, 0, 0, 0, 1, 0, 1, 9, 9));
        add(1, 0, 1, 0, 0, 0, 0, 0, ex(ST_D, 9, 9, 0, 0, 0, 0, 1, 1, 9, 9));
        add(1, 0, 0, 0, 0, 0, 0, 0, ex(ST_I, 9, 9, 0, 0, 0, 0, 0, 1, 9, 9));
`endif
        foreach (tbl[i]) step(tbl[i], i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
